// File: rtl/sdram_wr_feeder.sv
// Pixel FIFO and burst-request arbiter in front of the SDRAM controller; request pulse 1 cycle after selection.
// No upstream backpressure: pushes into a full FIFO are dropped (sticky overflow), pops on empty are ignored (sticky underflow).
module sdram_wr_feeder #(
  parameter int BURST = 256,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vsync,
  input  logic          pix_valid,
  input  logic [15:0]   pix_data,
  input  logic          rd_req,
  input  logic          sd_ready,
  input  logic          rd_ena,
  output logic          wr,
  output logic          rd,
  output logic [15:0]   data,
  output logic [AW:0]   fill,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, DONE} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HI_LVL   = (AW+1)'(DEPTH - BURST);
  localparam logic [AW:0] LO_LVL   = (AW+1)'(BURST);

  state_t        state, state_nxt;
  logic          kind, kind_nxt;  // 1 = write burst, 0 = read burst
  logic [AW:0]   wptr, rptr, rptr_nxt;
  logic [15:0]   mem [DEPTH];
  logic          vs_s1, vs_s2, vs_s3, flush_pend;
  logic          empty, full, pop, push, flush;
  logic [AW-1:0] waddr, raddr_nxt;
  logic          bypass, data_ld;

  assign fill  = wptr - rptr;
  assign empty = (fill == '0);
  assign full  = (fill == FULL_LVL);
  assign pop   = rd_ena && !empty;
  assign flush = flush_pend && (state == IDLE) && !rd_ena;
  // A simultaneous pop or flush frees a slot, so the push is kept even when full.
  assign push  = pix_valid && (!full || pop || flush);

  assign rptr_nxt  = flush ? wptr : rptr + (AW+1)'(pop);
  assign waddr     = wptr[AW-1:0];
  assign raddr_nxt = rptr_nxt[AW-1:0];
  // Word being written lands exactly at the next head: forward it past the memory.
  assign bypass    = push && (waddr == raddr_nxt);
  assign data_ld   = pop || bypass;

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    case (state)
      IDLE: begin
        if (sd_ready && !flush && (fill >= HI_LVL || rd_req || fill >= LO_LVL)) begin
          state_nxt = REQ;
          kind_nxt  = (fill >= HI_LVL) || !rd_req;
        end
      end
      REQ:  state_nxt = ACK;
      ACK:  if (!sd_ready) state_nxt = DONE;
      DONE: if (sd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[waddr] <= pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_s3      <= 1'b0;
      flush_pend <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      data       <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      state      <= IDLE;
      kind       <= 1'b0;
      wr         <= 1'b0;
      rd         <= 1'b0;
    end else begin
      vs_s1 <= i_vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
      if (vs_s2 && !vs_s3) flush_pend <= 1'b1;
      else if (flush)      flush_pend <= 1'b0;

      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr_nxt;
      if (data_ld) data <= bypass ? pix_data : mem[raddr_nxt];

      if (flush)                  overflow <= 1'b0;
      else if (pix_valid && !push) overflow <= 1'b1;
      if (flush)                  underflow <= 1'b0;
      else if (rd_ena && empty)   underflow <= 1'b1;

      state <= state_nxt;
      kind  <= kind_nxt;
      wr    <= (state_nxt == REQ) && kind_nxt && (state == IDLE);
      rd    <= (state_nxt == REQ) && !kind_nxt && (state == IDLE);
    end
  end

endmodule

// File: tb/tb_sdram_wr_feeder.sv
// Bench for sdram_wr_feeder: vector table, directed burst sequences and a random run against a queue-based model.
module tb_sdram_wr_feeder;
  localparam int BURST = 256;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_vsync = 1'b0, pix_valid = 1'b0, rd_req = 1'b0, sd_ready = 1'b0, rd_ena = 1'b0;
  logic [15:0] pix_data = '0;
  logic        wr, rd, overflow, underflow;
  logic [15:0] data;
  logic [AW:0] fill;

  always #5 clk = ~clk;

  sdram_wr_feeder #(.BURST(BURST), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .rd_req(rd_req), .sd_ready(sd_ready), .rd_ena(rd_ena), .wr(wr), .rd(rd), .data(data),
    .fill(fill), .overflow(overflow), .underflow(underflow)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, handshake as named phases.
  typedef enum {PH_IDLE, PH_PULSE, PH_WAIT_ACCEPT, PH_WAIT_RELEASE} phase_t;
  logic [15:0] mq[$];
  bit          m_ovf, m_unf, m_wr, m_rd, m_fpend;
  bit [2:0]    m_vs;
  phase_t      ph;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_wr = 0; m_rd = 0; m_fpend = 0; m_vs = '0;
    ph = PH_IDLE;
  endtask

  task automatic cycle();
    int n;
    bit pop, flush, push, full, go, wrk, rise;
    n     = mq.size();
    pop   = rd_ena && n > 0;
    flush = m_fpend && ph == PH_IDLE && !rd_ena;
    full  = (n == DEPTH);
    push  = pix_valid && (!full || pop || flush);
    go = 0; wrk = 0;
    m_wr = 0; m_rd = 0;
    case (ph)
      PH_IDLE: if (sd_ready && !flush) begin
        if (n >= DEPTH - BURST) begin go = 1; wrk = 1; end
        else if (rd_req)        begin go = 1; wrk = 0; end
        else if (n >= BURST)    begin go = 1; wrk = 1; end
        if (go) begin ph = PH_PULSE; m_wr = wrk; m_rd = !wrk; end
      end
      PH_PULSE:        ph = PH_WAIT_ACCEPT;
      PH_WAIT_ACCEPT:  if (!sd_ready) ph = PH_WAIT_RELEASE;
      PH_WAIT_RELEASE: if (sd_ready) ph = PH_IDLE;
      default:         ph = PH_IDLE;
    endcase
    if (flush) begin m_ovf = 0; m_unf = 0; end
    if (pix_valid && !push) m_ovf = 1;
    if (rd_ena && n == 0) m_unf = 1;
    rise = m_vs[1] && !m_vs[2];
    if (rise) m_fpend = 1;
    else if (flush) m_fpend = 0;
    m_vs = {m_vs[1], m_vs[0], i_vsync};
    if (flush) mq.delete();
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(pix_data);
    @(posedge clk); #1;
    check("m_fill", int'(fill), mq.size());
    check("m_ovf", int'(overflow), int'(m_ovf));
    check("m_unf", int'(underflow), int'(m_unf));
    check("m_wr", int'(wr), int'(m_wr));
    check("m_rd", int'(rd), int'(m_rd));
    if (mq.size() > 0) check("m_data", int'(data), int'(mq[0]));
  endtask

  task automatic do_reset();
    i_vsync = 0; pix_valid = 0; rd_req = 0; sd_ready = 0; rd_ena = 0; pix_data = '0;
    #3 rst_n = 0;
    #1;
    check("rst_fill", int'(fill), 0);
    check("rst_wr", int'(wr), 0);
    check("rst_rd", int'(rd), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_unf", int'(underflow), 0);
    check("rst_data", int'(data), 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1; pix_data = 16'(base + i);
      cycle();
    end
    pix_valid = 0;
  endtask

  // code: 0 = neither within budget, 1 = wr came first, 2 = rd came first
  task automatic wait_first(input int max, output int code);
    code = 0;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (wr) code = 1;
      else if (rd) code = 2;
      if (code != 0) break;
    end
  endtask

  typedef struct {
    bit          pv;
    logic [15:0] pd;
    bit          re, rq, sr;
    int          e_fill;
    bit          chk_d;
    logic [15:0] e_data;
    bit          e_wr, e_rd, e_ovf, e_unf;
  } vec_t;

  vec_t tbl[10];
  int   pv_pct[8] = '{70, 95, 95, 95, 20, 50, 5, 60};
  int   re_pct[8] = '{30, 0, 0, 3, 80, 50, 95, 40};

  initial begin
    int code;
    //         pv  pd        re rq sr fill chk data      wr rd ovf unf
    tbl[0] = '{0, 16'h0000, 1, 0, 0, 0,   1, 16'h0000, 0, 0, 0, 1};
    tbl[1] = '{1, 16'h00A1, 0, 0, 0, 1,   1, 16'h00A1, 0, 0, 0, 1};
    tbl[2] = '{1, 16'h00A2, 1, 0, 0, 1,   1, 16'h00A2, 0, 0, 0, 1};
    tbl[3] = '{0, 16'h0000, 1, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 1};
    tbl[4] = '{1, 16'h00A3, 0, 1, 1, 1,   1, 16'h00A3, 0, 1, 0, 1};
    tbl[5] = '{0, 16'h0000, 0, 0, 1, 1,   1, 16'h00A3, 0, 0, 0, 1};
    tbl[6] = '{0, 16'h0000, 0, 0, 0, 1,   1, 16'h00A3, 0, 0, 0, 1};
    tbl[7] = '{0, 16'h0000, 0, 0, 1, 1,   1, 16'h00A3, 0, 0, 0, 1};
    tbl[8] = '{0, 16'h0000, 0, 1, 1, 1,   1, 16'h00A3, 0, 1, 0, 1};
    tbl[9] = '{0, 16'h0000, 0, 0, 1, 1,   1, 16'h00A3, 0, 0, 0, 1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      pix_valid = tbl[i].pv; pix_data = tbl[i].pd; rd_ena = tbl[i].re;
      rd_req = tbl[i].rq; sd_ready = tbl[i].sr;
      cycle();
      check($sformatf("tbl%0d_fill", i), int'(fill), tbl[i].e_fill);
      if (tbl[i].chk_d) check($sformatf("tbl%0d_data", i), int'(data), int'(tbl[i].e_data));
      check($sformatf("tbl%0d_wr", i), int'(wr), int'(tbl[i].e_wr));
      check($sformatf("tbl%0d_rd", i), int'(rd), int'(tbl[i].e_rd));
      check($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].e_ovf));
      check($sformatf("tbl%0d_unf", i), int'(underflow), int'(tbl[i].e_unf));
    end

    // One burst in, write requested 2 cycles after the last push, then drained in order.
    do_reset();
    sd_ready = 1;
    push_n(256, 0);
    check("A_fill_256", int'(fill), 256);
    check("A_wr_plus1", int'(wr), 0);
    cycle();
    check("A_wr_plus2", int'(wr), 1);
    sd_ready = 0; rd_ena = 1;
    for (int i = 0; i < 256; i++) begin
      check("A_data_seq", int'(data), i);
      cycle();
    end
    rd_ena = 0;
    check("A_fill_drained", int'(fill), 0);
    check("A_unf_clear", int'(underflow), 0);
    sd_ready = 1;
    cycle(); cycle();

    // Display read beats a low-level write; write follows after the handshake.
    do_reset();
    push_n(300, 16'h1000);
    rd_req = 1; sd_ready = 1;
    wait_first(10, code);
    check("B_rd_first", code, 2);
    rd_req = 0; sd_ready = 0;
    cycle(); cycle();
    sd_ready = 1;
    wait_first(10, code);
    check("B_then_wr", code, 1);

    // Near-full write beats a pending read; read follows once drained below the high mark.
    do_reset();
    push_n(800, 16'h2000);
    rd_req = 1; sd_ready = 1;
    wait_first(10, code);
    check("C_wr_wins", code, 1);
    sd_ready = 0; rd_ena = 1;
    repeat (256) cycle();
    rd_ena = 0; sd_ready = 1;
    wait_first(10, code);
    check("C_then_rd", code, 2);
    check("C_fill_544", int'(fill), 544);

    // Overflow, then vsync flush while idle (reset here also lands mid-burst).
    do_reset();
    push_n(1025, 0);
    check("D_fill_full", int'(fill), 1024);
    check("D_ovf_set", int'(overflow), 1);
    i_vsync = 1;
    cycle();
    i_vsync = 0;
    cycle(); cycle();
    check("D_fill_before_flush", int'(fill), 1024);
    cycle();
    check("D_fill_flushed", int'(fill), 0);
    check("D_ovf_cleared", int'(overflow), 0);

    // Push and pop together while full.
    do_reset();
    push_n(1024, 16'h3000);
    check("E_fill_full", int'(fill), 1024);
    pix_valid = 1; pix_data = 16'hBEEF; rd_ena = 1;
    cycle();
    pix_valid = 0; rd_ena = 0;
    check("E_fill_stays", int'(fill), 1024);
    check("E_no_ovf", int'(overflow), 0);
    check("E_data_next", int'(data), 16'h3001);

    // Randomized traffic against the model.
    do_reset();
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 500; i++) begin
        pix_valid = ($urandom_range(0, 99) < pv_pct[b]);
        pix_data  = 16'($urandom);
        rd_ena    = ($urandom_range(0, 99) < re_pct[b]);
        rd_req    = ($urandom_range(0, 3) == 0);
        sd_ready  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 149) == 0) i_vsync = ~i_vsync;
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
